// File: rtl/au_seq_ctrl.sv
// Operation sequencer in front of the 32-bit arithmetic unit: accepts one request,
// issues it to the AU, waits the per-op latency, and returns one captured response.
module au_seq_ctrl #(
  parameter int unsigned ADDSUB_CYCLES = 1,
  parameter int unsigned MUL_CYCLES    = 32,
  parameter int unsigned DIV_CYCLES    = 32
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [1:0]  req_op,

  output logic [31:0] au_a,
  output logic [31:0] au_b,
  output logic [1:0]  au_op,
  output logic        au_start,
  input  logic [31:0] au_s,
  input  logic [31:0] au_hi,
  input  logic [31:0] au_lo,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_s,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic [1:0]  rsp_op,
  output logic        rsp_zero,
  output logic        rsp_divzero,

  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Counter preload is LAT-1 so EXEC spans exactly LAT cycles including the capture cycle.
  localparam logic [5:0] ADDSUB_PRELOAD = 6'(ADDSUB_CYCLES - 1);
  localparam logic [5:0] MUL_PRELOAD    = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_PRELOAD    = 6'(DIV_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [5:0] cnt;
  logic [5:0] preload;
  logic       accept;
  logic       div_by_zero;
  logic       issue;
  logic       last_exec;
  logic       result_zero;

  assign accept      = (state == IDLE) && req_valid;
  assign div_by_zero = (req_op == OP_DIV) && (req_b == 32'd0);
  assign issue       = accept && !div_by_zero;
  assign last_exec   = (state == EXEC) && (cnt == 6'd0);

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    preload = ADDSUB_PRELOAD;
    case (req_op)
      OP_MUL:  preload = MUL_PRELOAD;
      OP_DIV:  preload = DIV_PRELOAD;
      default: preload = ADDSUB_PRELOAD;
    endcase
  end

  always_comb begin
    result_zero = 1'b0;
    case (au_op)
      OP_ADD, OP_SUB: result_zero = (au_s == 32'd0);
      OP_MUL:         result_zero = ({au_hi, au_lo} == 64'd0);
      OP_DIV:         result_zero = (au_lo == 32'd0);
      default:        result_zero = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid) state_next = div_by_zero ? DONE : EXEC;
      EXEC: if (cnt == 6'd0) state_next = DONE;
      DONE: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      au_a        <= '0;
      au_b        <= '0;
      au_op       <= '0;
      au_start    <= 1'b0;
      cnt         <= '0;
      rsp_s       <= '0;
      rsp_hi      <= '0;
      rsp_lo      <= '0;
      rsp_op      <= '0;
      rsp_zero    <= 1'b0;
      rsp_divzero <= 1'b0;
    end else begin
      au_start <= issue;

      if (accept) begin
        au_a  <= req_a;
        au_b  <= req_b;
        au_op <= req_op;
        cnt   <= preload;
      end else if ((state == EXEC) && (cnt != 6'd0)) begin
        cnt <= cnt - 6'd1;
      end

      // A divide by zero never reaches the AU; its response is formed directly here.
      if (accept && div_by_zero) begin
        rsp_s       <= '0;
        rsp_hi      <= req_a;
        rsp_lo      <= 32'hFFFF_FFFF;
        rsp_op      <= OP_DIV;
        rsp_zero    <= 1'b0;
        rsp_divzero <= 1'b1;
      end else if (last_exec) begin
        rsp_s       <= au_s;
        rsp_hi      <= au_hi;
        rsp_lo      <= au_lo;
        rsp_op      <= au_op;
        rsp_zero    <= result_zero;
        rsp_divzero <= 1'b0;
      end
    end
  end

  au_start_in_exec: assert property (@(posedge clk) disable iff (rst)
    au_start |-> (state == EXEC));

  operands_stable: assert property (@(posedge clk) disable iff (rst)
    ((state == EXEC) && ($past(state) == EXEC)) |-> $stable({au_a, au_b, au_op}));

endmodule

// File: tb/tb_au_seq_ctrl.sv
// Self-checking bench for au_seq_ctrl: directed and random operations compared
// against an arithmetic reference of the expected response and its timing.
`timescale 1ns/1ps
module tb_au_seq_ctrl;

  localparam int ADDSUB_LAT = 1;
  localparam int MUL_LAT    = 32;
  localparam int DIV_LAT    = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [1:0]  req_op = '0;
  logic [31:0] au_a, au_b;
  logic [1:0]  au_op;
  logic        au_start;
  logic [31:0] au_s, au_hi, au_lo;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_s, rsp_hi, rsp_lo;
  logic [1:0]  rsp_op;
  logic        rsp_zero, rsp_divzero, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  au_seq_ctrl #(
    .ADDSUB_CYCLES(ADDSUB_LAT),
    .MUL_CYCLES   (MUL_LAT),
    .DIV_CYCLES   (DIV_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .au_a(au_a), .au_b(au_b), .au_op(au_op), .au_start(au_start),
    .au_s(au_s), .au_hi(au_hi), .au_lo(au_lo),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_op(rsp_op),
    .rsp_zero(rsp_zero), .rsp_divzero(rsp_divzero),
    .busy(busy)
  );

  // Arithmetic unit stand-in: results settle from the registered operands.
  always_comb begin
    logic [63:0] prod;
    prod  = 64'(au_a) * 64'(au_b);
    au_s  = (au_op == 2'b01) ? au_a - au_b : au_a + au_b;
    au_hi = '0;
    au_lo = '0;
    if (au_op == 2'b10) begin
      au_hi = prod[63:32];
      au_lo = prod[31:0];
    end else if (au_op == 2'b11 && au_b != 0) begin
      au_hi = au_a % au_b;
      au_lo = au_a / au_b;
    end
  end

  typedef struct {
    logic [31:0] s, hi, lo;
    logic        zero, divz;
    int          lat;
  } exp_t;

  function automatic exp_t model(input logic [31:0] a, b, input logic [1:0] op);
    exp_t e;
    logic [63:0] p;
    e.s = a + b; e.hi = '0; e.lo = '0; e.divz = 1'b0;
    case (op)
      2'b00: begin e.zero = (a + b == 0); e.lat = ADDSUB_LAT + 1; end
      2'b01: begin e.s = a - b; e.zero = (a == b); e.lat = ADDSUB_LAT + 1; end
      2'b10: begin
        p = 64'(a) * 64'(b);
        e.hi = p[63:32]; e.lo = p[31:0];
        e.zero = (a == 0) || (b == 0);
        e.lat = MUL_LAT + 1;
      end
      default: begin
        if (b == 0) begin
          e.s = '0; e.hi = a; e.lo = 32'hFFFF_FFFF;
          e.zero = 1'b0; e.divz = 1'b1; e.lat = 1;
        end else begin
          e.hi = a % b; e.lo = a / b;
          e.zero = (a < b);
          e.lat = DIV_LAT + 1;
        end
      end
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request, follows it to its response, optionally stalls the
  // consumer while a rival request is offered, then completes the handshake.
  task automatic run_op(input logic [31:0] a, b, input logic [1:0] op, input int stall);
    exp_t e;
    int   cyc, starts, first_start;
    e = model(a, b, op);
    @(negedge clk);
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
    rsp_ready = (stall == 0);
    cyc = 0; starts = 0; first_start = -1;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) req_valid = 1'b0;
      if (au_start) begin
        starts++;
        if (first_start < 0) first_start = cyc;
      end
      check("busy_hold", {req_ready, busy}, 2'b01);
      if (!rsp_valid && !e.divz)
        check("au_hold", {au_op, au_a, au_b}, {op, a, b});
    end while (!rsp_valid && cyc < 100);
    check("rsp_latency", cyc, e.lat);
    check("au_start_count", starts, e.divz ? 0 : 1);
    if (!e.divz) check("au_start_pos", first_start, 1);
    check("rsp_s", rsp_s, e.s);
    check("rsp_hi", rsp_hi, e.hi);
    check("rsp_lo", rsp_lo, e.lo);
    check("rsp_flags", {rsp_op, rsp_zero, rsp_divzero}, {op, e.zero, e.divz});
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1; req_a = $urandom; req_b = $urandom; req_op = 2'($urandom);
      @(negedge clk);
      check("stall_hold", {rsp_valid, req_ready, rsp_op, rsp_lo, rsp_hi},
            {1'b1, 1'b0, op, e.lo, e.hi});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("after_handshake", {rsp_valid, req_ready, busy}, 3'b010);
    check("rsp_persist", {rsp_s, rsp_lo}, {e.s, e.lo});
    rsp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, b;
    logic [1:0]  op;
    int          seen;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {req_ready, busy, rsp_valid, au_start}, 4'b1000);
    check("reset_au", {au_op, au_a, au_b}, 66'd0);
    check("reset_rsp", {rsp_op, rsp_zero, rsp_divzero, rsp_s, rsp_hi}, 68'd0);
    rst = 1'b0;

    run_op(32'd5, 32'd7, 2'b00, 0);
    run_op(32'd9, 32'd9, 2'b01, 0);
    run_op(32'h0001_0000, 32'h0001_0000, 2'b10, 0);
    run_op(32'd100, 32'd0, 2'b11, 0);
    run_op(32'd100, 32'd7, 2'b11, 5);
    run_op(32'd3, 32'd9, 2'b11, 0);

    // Reset in the middle of a multiply discards it without a response.
    @(negedge clk);
    req_valid = 1'b1; req_a = 32'd12345; req_b = 32'd678; req_op = 2'b10;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_busy", {busy, rsp_valid}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_reset", {req_ready, busy, rsp_valid, au_start}, 4'b1000);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    check("no_orphan_rsp", seen, 0);
    rsp_ready = 1'b0;
    run_op(32'd1, 32'd1, 2'b00, 0);

    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = a;
        default: b = $urandom;
      endcase
      run_op(a, b, op, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
